// File: rtl/bus_arbiter_param_if.sv
// Request/grant and shared-bus status signals between the masters and the arbiter.
interface bus_arbiter_param_if #(
  parameter int unsigned NUM_MASTERS = 12,
  parameter int unsigned NUM_SLAVES  = 6
);
  logic [NUM_MASTERS-1:0] m_reqs;
  logic [NUM_MASTERS-1:0] m_grants;
  logic [NUM_SLAVES-1:0]  slaves;
  logic                   bus_util;

  // Bus side: drives requests, busy flags and utilisation, observes grants.
  modport master (
    output m_reqs,
    output slaves,
    output bus_util,
    input  m_grants
  );

  // Arbiter side.
  modport slave (
    input  m_reqs,
    input  slaves,
    input  bus_util,
    output m_grants
  );
endinterface

// File: rtl/bus_arbiter_param.sv
// Parametrised bus arbiter: fixed-priority or round-robin selection, grant watchdog,
// slave-busy hold-off after each transaction, saturating bus-utilisation counter.
// All outputs come straight from registers.
module bus_arbiter_param #(
  parameter int unsigned NUM_MASTERS = 12,
  parameter int unsigned NUM_SLAVES  = 6,
  parameter int unsigned MID_WIDTH   = 4,
  parameter int unsigned TIMEOUT_LEN = 6,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  bus_arbiter_param_if.slave   bus,
  input  logic                 rr_mode,
  output logic [MID_WIDTH-1:0] mid_current,
  output logic [1:0]           state,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] util_count
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StBusy    = 2'd2,
    StRelease = 2'd3
  } state_e;

  state_e                 r_state;
  logic [NUM_MASTERS-1:0] r_grants;
  logic [MID_WIDTH-1:0]   r_mid;
  logic [MID_WIDTH-1:0]   r_ptr;
  logic [TIMEOUT_LEN-1:0] r_wdog;
  logic                   r_timeout_err;
  logic [CNT_WIDTH-1:0]   r_util_cnt;

  logic [MID_WIDTH-1:0]   w_fp_idx;
  logic [MID_WIDTH-1:0]   w_rr_idx;
  logic                   w_rr_found;
  logic [MID_WIDTH-1:0]   w_win;
  logic                   w_any_req;
  logic                   w_cur_req;
  logic                   w_slaves_busy;
  int                     w_scan;

  assign w_any_req     = |bus.m_reqs;
  assign w_cur_req     = bus.m_reqs[r_mid];
  assign w_slaves_busy = |bus.slaves[NUM_SLAVES-1:0];

  // Winner selection for both policies; rr_mode only picks which result is used.
  always_comb begin
    w_fp_idx   = '0;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    w_scan     = 0;
    // Downward scan so the lowest set index is the last one written.
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (bus.m_reqs[i]) begin
        w_fp_idx = MID_WIDTH'(i);
      end
    end
    // Upward scan from pointer+1, wrapping; k = NUM_MASTERS revisits the pointer itself last.
    for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
      w_scan = (int'(r_ptr) + k) % int'(NUM_MASTERS);
      if (!w_rr_found && bus.m_reqs[MID_WIDTH'(w_scan)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = MID_WIDTH'(w_scan);
      end
    end
    w_win = rr_mode ? w_rr_idx : w_fp_idx;
  end

  // Arbitration FSM with registered grant, watchdog and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= StIdle;
      r_grants      <= '0;
      r_mid         <= '0;
      r_ptr         <= MID_WIDTH'(NUM_MASTERS - 1);
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_grants <= '0;
          // Stray utilisation blocks arbitration.
          if (!bus.bus_util && w_any_req) begin
            r_grants <= NUM_MASTERS'(1) << w_win;
            r_mid    <= w_win;
            r_ptr    <= w_win;
            r_wdog   <= '0;
            r_state  <= StGrant;
          end
        end
        StGrant: begin
          // Priority order matters: utilisation beats both withdrawal and timeout.
          if (bus.bus_util) begin
            r_state <= StBusy;
          end else if (!w_cur_req) begin
            r_grants <= '0;
            r_state  <= StIdle;
          end else if (r_wdog == {TIMEOUT_LEN{1'b1}}) begin
            r_grants      <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_wdog <= r_wdog + TIMEOUT_LEN'(1);
          end
        end
        StBusy: begin
          if (!bus.bus_util) begin
            r_grants <= '0;
            r_state  <= StRelease;
          end
        end
        StRelease: begin
          r_grants <= '0;
          if (!w_slaves_busy) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_grants <= '0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  // Saturating count of utilised cycles, independent of FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_util_cnt <= '0;
    end else if (bus.bus_util && (r_util_cnt != {CNT_WIDTH{1'b1}})) begin
      r_util_cnt <= r_util_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.m_grants = r_grants;
  assign mid_current  = r_mid;
  assign state        = r_state;
  assign timeout_err  = r_timeout_err;
  assign util_count   = r_util_cnt;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// Directed bench for bus_arbiter_param: reset, fixed priority, round robin,
// slave hold-off, request withdrawal, watchdog and utilisation counter.
module tb_bus_arbiter_param;

  localparam int unsigned NM = 12;
  localparam int unsigned NS = 6;
  localparam int unsigned MW = 4;
  localparam int unsigned TL = 6;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [NM-1:0] grant;
    logic [MW-1:0] mid;
    int            lat;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          rr_mode;
  logic [MW-1:0] mid_current;
  logic [1:0]    state;
  logic          timeout_err;
  logic [CW-1:0] util_count;

  int   n_checks;
  int   n_fail;
  int   wd_cnt;
  exp_t sb[$];

  bus_arbiter_param_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_if ();

  bus_arbiter_param #(
    .NUM_MASTERS(NM),
    .NUM_SLAVES (NS),
    .MID_WIDTH  (MW),
    .TIMEOUT_LEN(TL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus_if.slave),
    .rr_mode    (rr_mode),
    .mid_current(mid_current),
    .state      (state),
    .timeout_err(timeout_err),
    .util_count (util_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a grant, compare against the scoreboard, run 3 busy cycles, then release.
  // With hold > 0 the slaves stay busy for hold cycles and the re-grant is checked.
  task automatic txn(input int hold);
    int   n;
    exp_t e;
    n = 0;
    do begin
      step();
      n++;
    end while (bus_if.m_grants == '0 && n < 20);
    e = sb.pop_front();
    chk("grant", 32'(bus_if.m_grants), 32'(e.grant));
    chk("mid", 32'(mid_current), 32'(e.mid));
    chk("latency", 32'(n), 32'(e.lat));
    bus_if.bus_util = 1'b1;
    step();
    chk("busy_state", 32'(state), 32'd2);
    step();
    step();
    chk("busy_grant_held", 32'(bus_if.m_grants), 32'(e.grant));
    if (hold > 0) bus_if.slaves = 6'b000100;
    bus_if.bus_util = 1'b0;
    if (hold > 0) begin
      step();
      for (int i = 0; i < hold; i++) begin
        chk("holdoff_state", 32'(state), 32'd3);
        chk("holdoff_grant", 32'(bus_if.m_grants), 32'd0);
        if (i == hold - 1) bus_if.slaves = '0;
        else step();
      end
      step();
      chk("holdoff_idle", 32'(state), 32'd0);
      step();
      chk("holdoff_regrant", 32'(bus_if.m_grants), 32'(e.grant));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset with everything active on the inputs.
    rstn            = 1'b0;
    rr_mode         = 1'b0;
    bus_if.m_reqs   = 12'hFFF;
    bus_if.bus_util = 1'b1;
    bus_if.slaves   = '0;
    repeat (3) step();
    chk("rst_grants", 32'(bus_if.m_grants), 32'd0);
    chk("rst_mid", 32'(mid_current), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_util", 32'(util_count), 32'd0);
    bus_if.m_reqs   = '0;
    bus_if.bus_util = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("idle_state", 32'(state), 32'd0);

    // Fixed priority: 0x034 always resolves to master 2.
    rr_mode       = 1'b0;
    bus_if.m_reqs = 12'h034;
    sb.push_back('{12'h004, 4'd2, 1});
    sb.push_back('{12'h004, 4'd2, 3});
    sb.push_back('{12'h004, 4'd2, 3});
    repeat (3) txn(0);

    // Still in BUSY here; reset must clear outputs before the next edge.
    chk("pre_rst_state", 32'(state), 32'd2);
    chk("pre_rst_util", 32'(util_count), 32'd9);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_grants", 32'(bus_if.m_grants), 32'd0);
    chk("async_rst_util", 32'(util_count), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_mid", 32'(mid_current), 32'd0);
    rr_mode = 1'b1;
    step();
    rstn = 1'b1;

    // Round robin from the reset pointer.
    sb.push_back('{12'h004, 4'd2, 1});
    sb.push_back('{12'h010, 4'd4, 3});
    sb.push_back('{12'h020, 4'd5, 3});
    sb.push_back('{12'h004, 4'd2, 3});
    repeat (4) txn(0);

    // Slave hold-off after a transaction.
    bus_if.m_reqs = 12'h004;
    sb.push_back('{12'h004, 4'd2, 3});
    txn(5);

    // Request withdrawal in GRANT: no error.
    bus_if.m_reqs = '0;
    step();
    chk("withdraw_grant", 32'(bus_if.m_grants), 32'd0);
    chk("withdraw_timeout", 32'(timeout_err), 32'd0);
    chk("withdraw_state", 32'(state), 32'd0);

    // Watchdog: grant lasts exactly 2^TL cycles, then one-cycle error and re-grant.
    bus_if.m_reqs = 12'h010;
    step();
    chk("wd_first_grant", 32'(bus_if.m_grants), 32'h010);
    wd_cnt = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus_if.m_grants != 12'h010) break;
      wd_cnt++;
    end
    chk("wd_length", 32'(wd_cnt), 32'd64);
    chk("wd_timeout_pulse", 32'(timeout_err), 32'd1);
    chk("wd_dropped", 32'(bus_if.m_grants), 32'd0);
    step();
    chk("wd_timeout_clear", 32'(timeout_err), 32'd0);
    chk("wd_regrant", 32'(bus_if.m_grants), 32'h010);
    chk("wd_regrant_mid", 32'(mid_current), 32'd4);

    // bus_util arriving on the terminal watchdog cycle wins: BUSY, no error.
    repeat (63) step();
    chk("wd_term_grant", 32'(bus_if.m_grants), 32'h010);
    bus_if.bus_util = 1'b1;
    step();
    chk("wd_term_state", 32'(state), 32'd2);
    chk("wd_term_timeout", 32'(timeout_err), 32'd0);
    chk("wd_term_grant_held", 32'(bus_if.m_grants), 32'h010);

    // Counter saturation, with stray utilisation in IDLE.
    rstn = 1'b0;
    #1;
    bus_if.m_reqs   = '0;
    bus_if.bus_util = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("cnt_start", 32'(util_count), 32'd0);
    bus_if.bus_util = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("cnt_value", 32'(util_count), 32'((i > 15) ? 15 : i));
    end
    chk("stray_util_state", 32'(state), 32'd0);
    chk("stray_util_grants", 32'(bus_if.m_grants), 32'd0);
    bus_if.bus_util = 1'b0;
    step();
    chk("cnt_hold", 32'(util_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_param.md
# bus_arbiter_param

Parametrised successor to the fixed 12-master bus controller: arbitrates up to NUM_MASTERS serial-bus masters, with fixed-priority or round-robin policy selectable at run time. It sits between the masters' request/grant pins and the shared b_BUS/b_RW/b_bus_utilizing nets in the bus top level. It adds three things:
- a grant-acceptance watchdog;
- a hold-off that keeps the bus idle while any slave is still busy;
- a saturating bus-utilisation counter for on-board reporting.

## Interface
- NUM_MASTERS, 12, number of request/grant pairs (2..16)
- NUM_SLAVES, 6, number of slave_busy inputs
- MID_WIDTH, 4, width of mid_current; must be ≥ clog2(NUM_MASTERS)
- TIMEOUT_LEN, 6, watchdog width in bits; grant times out after 2^TIMEOUT_LEN cycles
- CNT_WIDTH, 16, width of util_count
- clk  input  1  system clock; all logic is on its rising edge
- rstn  input  1  reset, asynchronous, active-low
- m_reqs  input  NUM_MASTERS  request per master; bit i = master i
- rr_mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin
- slaves  input  NUM_SLAVES  slave busy flags (pulled down on the bus)
- bus_util  input  1  b_bus_utilizing from the bus
- m_grants  output  NUM_MASTERS  one-hot grant, or all zero
- mid_current  output  MID_WIDTH  index of the most recently granted master
- state  output  2  FSM state: 0 IDLE, 1 GRANT, 2 BUSY, 3 RELEASE
- timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog
- util_count  output  CNT_WIDTH  count of cycles with bus_util=1, saturating

## Operation
- **IDLE**
  - m_grants=0.
  - If bus_util=0 and m_reqs≠0, choose a winner W, register grant bit W, set mid_current=W, set the RR pointer to W, then go to GRANT.
  - If bus_util=1 (stray utilisation), no arbitration; stay in IDLE.
- **Winner selection**
  - Fixed priority: the lowest set index.
  - Round robin: the first set index scanning upward from pointer+1, wrapping at NUM_MASTERS-1 → 0.
  - The pointer updates on every grant in both modes. A change to rr_mode takes effect at the next arbitration.
- **GRANT**
  - The grant is held. The watchdog counter starts at 0 and increments each GRANT cycle.
  - Exits are evaluated in this order:
    - bus_util=1 → BUSY;
    - m_reqs[W]=0 → IDLE, grant dropped, no error;
    - counter = 2^TIMEOUT_LEN-1 → IDLE, grant dropped, timeout_err=1 for that transition cycle.
  - If bus_util rises in the same cycle as the counter terminal value, BUSY wins and there is no error.
- **BUSY**
  - The grant is held while bus_util=1. The request level is ignored.
  - bus_util=0 → RELEASE.
- **RELEASE**
  - m_grants=0.
  - Stay while slaves≠0; when slaves=0 → IDLE. A new request is arbitrated in IDLE only.
- **util_count**: +1 in every cycle with bus_util=1, in any state; holds at all-ones; cleared only by reset.
- At most one bit of m_grants is ever set.
- Request bits at or above NUM_MASTERS do not exist. Bits for absent masters must be tied to 0 at the top level.

## Timing
- **Reset** (asynchronous, effective immediately, including mid-transaction): state=IDLE, m_grants=0, mid_current=0, timeout_err=0, util_count=0, watchdog=0, RR pointer=NUM_MASTERS-1 (so master 0 is first in RR).
- All outputs are registered; there are no combinational paths from input to output.
- **Arbitration latency**: a request sampled in IDLE at edge n drives its grant bit from edge n+1.
- **GRANT→BUSY**: bus_util sampled 1 at edge k gives state=BUSY from k+1.
- **Release**: bus_util sampled 0 at edge k in BUSY drops the grant from k+1.
  - With slaves=0, the FSM is in IDLE at k+2 and the earliest next grant is from k+3.
- **Watchdog**: with no bus_util, the grant is high for exactly 2^TIMEOUT_LEN cycles. timeout_err is high in the first cycle after the grant falls.
- **Request withdrawal in GRANT**: a request sampled 0 at edge k drops the grant from k+1.

## Test plan
- **Reset**: hold rstn=0 with m_reqs=12'hFFF and bus_util=1 → all outputs 0. Assert rstn=0 mid-BUSY → m_grants=0 and util_count=0 asynchronously, before the next edge.
- **Fixed priority**: rr_mode=0, m_reqs=12'h034 held; each grant answered by 3 cycles of bus_util=1 → every grant is 12'h004 with mid_current=2, and the first grant appears one cycle after the request.
- **Round robin**: rr_mode=1, same stimulus, four transactions → grants 12'h004, 12'h010, 12'h020, 12'h004; mid_current 2, 4, 5, 2.
- **Watchdog**: TIMEOUT_LEN=6, m_reqs=12'h010, bus_util held 0 → m_grants=12'h010 for exactly 64 cycles, then timeout_err pulses for 1 cycle and the FSM re-grants master 4 one cycle later.
- **Slave hold-off**: after a transaction completes, slaves=6'b000100 for 5 cycles with m_reqs=12'h004 → state=RELEASE and m_grants=0 for those 5 cycles, then the grant is reasserted 2 cycles after slaves returns to 0.
- **Counter**: CNT_WIDTH=4, bus_util=1 for 20 cycles → util_count reaches 15 and holds.
